// File: rtl/vector_mac_stream.sv
// Streaming int8 dot-product engine.
// Operand beats of LANES int8 pairs are multiplied, masked past the vector end,
// summed per beat and accumulated over a runtime vector length. The result is
// held with valid/ready until consumed; the next vector starts afterwards.
module vector_mac_stream #(
    parameter int unsigned LANES = 4,
    parameter int unsigned LEN_W = 16,
    parameter int unsigned ACC_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_a,
    input  logic [8*LANES-1:0] in_b,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               signed_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [LEN_W-1:0]   out_count
);

    localparam int unsigned SUM_W = 17 + $clog2(LANES);
    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {StAcc, StDrain, StHold} state_e;

    state_e state_q, state_d;
    logic [1:0] drain_q;

    logic [LEN_W-1:0] elem_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             signed_q;

    logic             beat_fire;
    logic             first_beat;
    logic             last_beat;
    logic [LEN_W-1:0] len_eff;
    logic             mode_eff;
    logic [CNT_W-1:0] rem;

    logic signed [16:0] prod   [LANES];
    logic signed [16:0] prod_q [LANES];
    logic               s1_vld_q, s1_first_q;

    logic signed [SUM_W-1:0] lane_sum;
    logic signed [SUM_W-1:0] sum_q;
    logic                    s2_vld_q, s2_first_q;
    logic [ACC_W-1:0]        sum_ext;
    logic [ACC_W-1:0]        acc_q;

    assign beat_fire  = in_valid & in_ready;
    assign first_beat = (elem_cnt_q == '0);
    // Length and mode come straight from the inputs on the first beat, then from the latches.
    assign len_eff    = first_beat ? ((len_i == '0) ? LEN_W'(1) : len_i) : len_q;
    assign mode_eff   = first_beat ? signed_i : signed_q;
    assign rem        = {1'b0, len_eff} - {1'b0, elem_cnt_q};
    assign last_beat  = (rem <= CNT_W'(LANES));

    // Per-lane 9-bit extension, 17-bit signed product, masked beyond the vector end.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic signed [8:0]  a_ext, b_ext;
        logic signed [16:0] full;
        assign a_ext   = {mode_eff & in_a[8*j+7], in_a[8*j +: 8]};
        assign b_ext   = {mode_eff & in_b[8*j+7], in_b[8*j +: 8]};
        assign full    = 17'(a_ext) * 17'(b_ext);
        assign prod[j] = (CNT_W'(j) < rem) ? full : '0;
    end

    // Element counter and per-vector latches; the counter clears when the result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt_q <= '0;
            len_q      <= '0;
            signed_q   <= 1'b0;
        end else if (beat_fire) begin
            elem_cnt_q <= last_beat ? len_eff : elem_cnt_q + LEN_W'(LANES);
            if (first_beat) begin
                len_q    <= len_eff;
                signed_q <= signed_i;
            end
        end else if (out_valid && out_ready) begin
            elem_cnt_q <= '0;
        end
    end

    // Stage 1: register masked products and the first-beat flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q     <= '{default: '0};
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
        end else begin
            s1_vld_q <= beat_fire;
            if (beat_fire) begin
                prod_q     <= prod;
                s1_first_q <= first_beat;
            end
        end
    end

    // Adder tree over the registered lane products.
    always_comb begin
        lane_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_sum = lane_sum + SUM_W'(prod_q[j]);
        end
    end

    // Stage 2: register the beat sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q      <= '0;
            s2_vld_q   <= 1'b0;
            s2_first_q <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                sum_q      <= lane_sum;
                s2_first_q <= s1_first_q;
            end
        end
    end

    assign sum_ext = ACC_W'(sum_q);

    // Stage 3: accumulate; the first beat of a vector restarts the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (s2_vld_q) begin
            acc_q <= s2_first_q ? sum_ext : acc_q + sum_ext;
        end
    end

    // FSM state register plus drain cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAcc;
            drain_q <= 2'd0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == StDrain) ? drain_q + 2'd1 : 2'd0;
        end
    end

    // FSM next state: three drain cycles let the last beat reach the accumulator.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAcc:   if (beat_fire && last_beat) state_d = StDrain;
            StDrain: if (drain_q == 2'd2) state_d = StHold;
            StHold:  if (out_ready) state_d = StAcc;
            default: state_d = StAcc;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StAcc:   in_ready = 1'b1;
            StDrain: ;
            StHold:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_sum   = acc_q;
    assign out_count = len_q;

endmodule

// File: tb/tb_vector_mac_stream.sv
// Bench for vector_mac_stream: a LANES=4 and a LANES=1 instance, randomized and
// directed vectors, reference dot products pushed to per-instance scoreboards.
module tb_vector_mac_stream;

    localparam int unsigned L4 = 4;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [31:0] sum;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n, rst_n1;

    logic        in_valid, in_ready, signed_i, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_sum;
    logic [15:0] len_i, out_count;

    logic        in_valid1, in_ready1, signed_i1, out_valid1, out_ready1;
    logic [7:0]  in_a1, in_b1;
    logic [31:0] out_sum1;
    logic [15:0] len_i1, out_count1;

    logic rand_rdy, man_rdy, rnd_rdy;
    logic go1, done1;

    int checks = 0;
    int failures = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    assign out_ready = rand_rdy ? rnd_rdy : man_rdy;

    vector_mac_stream #(.LANES(4), .LEN_W(16), .ACC_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .len_i(len_i), .signed_i(signed_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count)
    );

    vector_mac_stream #(.LANES(1), .LEN_W(16), .ACC_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
        .len_i(len_i1), .signed_i(signed_i1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_count(out_count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rnd_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1 rnd_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain arithmetic dot product over the first max(len,1) elements.
    function automatic logic [31:0] ref_dot(input int len, input bit sgn,
                                            input byte_q_t a, input byte_q_t b);
        longint s = 0;
        int n = (len == 0) ? 1 : len;
        for (int i = 0; i < n; i++) begin
            longint x, y;
            x = sgn ? longint'($signed(a[i])) : longint'(a[i]);
            y = sgn ? longint'($signed(b[i])) : longint'(b[i]);
            s += x * y;
        end
        return s[31:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut4_unexpected_result: got 0x%0h expected none", out_sum);
            end else begin
                chk("dut4_sum", 64'(out_sum), 64'(sb0[0].sum));
                chk("dut4_count", 64'(out_count), 64'(sb0[0].cnt));
                void'(sb0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n1 && out_valid1 && out_ready1) begin
            if (sb1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected_result: got 0x%0h expected none", out_sum1);
            end else begin
                chk("dut1_sum", 64'(out_sum1), 64'(sb1[0].sum));
                chk("dut1_count", 64'(out_count1), 64'(sb1[0].cnt));
                void'(sb1.pop_front());
            end
        end
    end

    // Present one beat (called at posedge+1) and return at posedge+1 after acceptance.
    task automatic drive_beat0(input logic [31:0] a, input logic [31:0] b,
                               input logic [15:0] len, input bit sgn);
        bit ok = 1'b0;
        int waited = 0;
        in_valid = 1'b1; in_a = a; in_b = b; len_i = len; signed_i = sgn;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1 waited++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL dut4_accept_timeout: got no in_ready expected in_ready within 200 cycles");
        end
    endtask

    task automatic drive_beat1(input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] len, input bit sgn);
        bit ok = 1'b0;
        int waited = 0;
        in_valid1 = 1'b1; in_a1 = a; in_b1 = b; len_i1 = len; signed_i1 = sgn;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (in_ready1) ok = 1'b1;
            @(posedge clk);
            #1 waited++;
        end
        in_valid1 = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL dut1_accept_timeout: got no in_ready expected in_ready within 200 cycles");
        end
    endtask

    // Non-first beats carry random len/mode to show they are latched on the first beat.
    task automatic send_vec0(input int len, input bit sgn, input byte_q_t a,
                             input byte_q_t b, input bit gaps);
        int n = (len == 0) ? 1 : len;
        int nb = (n + L4 - 1) / L4;
        sb0.push_back('{sum: ref_dot(len, sgn, a, b), cnt: 16'(n)});
        for (int bi = 0; bi < nb; bi++) begin
            logic [31:0] wa, wb;
            for (int j = 0; j < L4; j++) begin
                wa[8*j +: 8] = a[bi*L4+j];
                wb[8*j +: 8] = b[bi*L4+j];
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            if (bi == 0) drive_beat0(wa, wb, 16'(len), sgn);
            else drive_beat0(wa, wb, 16'($urandom), 1'($urandom));
        end
    endtask

    task automatic send_vec1(input int len, input bit sgn, input byte_q_t a, input byte_q_t b);
        int n = (len == 0) ? 1 : len;
        sb1.push_back('{sum: ref_dot(len, sgn, a, b), cnt: 16'(n)});
        for (int e = 0; e < n; e++) begin
            if (e == 0) drive_beat1(a[e], b[e], 16'(len), sgn);
            else drive_beat1(a[e], b[e], 16'($urandom), 1'($urandom));
        end
    endtask

    function automatic byte_q_t fill(input int n, input int val);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back((val < 0) ? 8'($urandom) : 8'(val));
        return q;
    endfunction

    task automatic wait_idle0();
        int waited = 0;
        while (sb0.size() != 0 && waited < 1000) begin
            @(posedge clk);
            #1 waited++;
        end
        if (sb0.size() != 0) begin
            checks++; failures++;
            $display("FAIL dut4_drain_timeout: got %0d pending expected 0", sb0.size());
        end
    endtask

    // LANES=1 instance: len=0 edge case, small random vectors, maximum length.
    initial begin
        byte_q_t a, b;
        int waited;
        wait (go1);
        @(posedge clk);
        #1;
        send_vec1(0, 1'b0, fill(1, 3), fill(1, 3));
        for (int t = 0; t < 4; t++) begin
            int len = $urandom_range(1, 9);
            send_vec1(len, 1'($urandom), fill(len, -1), fill(len, -1));
        end
        a = fill(65535, 8'hFF);
        b = fill(65535, 8'hFF);
        send_vec1(65535, 1'b0, a, b);
        waited = 0;
        while (sb1.size() != 0 && waited < 100) begin
            @(posedge clk);
            #1 waited++;
        end
        done1 = 1'b1;
    end

    initial begin
        byte_q_t a, b;
        int waited;
        rst_n = 1'b0; rst_n1 = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; len_i = '0; signed_i = 1'b0;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; len_i1 = '0; signed_i1 = 1'b0;
        out_ready1 = 1'b1;
        rand_rdy = 1'b0; man_rdy = 1'b0; go1 = 1'b0; done1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_sum", 64'(out_sum), 64'(0));
        chk("reset_out_count", 64'(out_count), 64'(0));
        chk("reset1_in_ready", 64'(in_ready1), 64'(1));
        rst_n = 1'b1; rst_n1 = 1'b1;
        go1 = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned all-0xFF single beat, with exact result latency.
        send_vec0(4, 1'b0, fill(4, 8'hFF), fill(4, 8'hFF), 1'b0);
        @(negedge clk);
        chk("t1_in_ready_drain", 64'(in_ready), 64'(0));
        chk("t1_valid_k0", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("t1_valid_k1", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("t1_valid_k2", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("t1_valid_k3", 64'(out_valid), 64'(1));
        chk("t1_sum_const", 64'(out_sum), 64'h3F804);
        @(posedge clk);
        #1 man_rdy = 1'b1;
        wait_idle0();

        // Signed extremes over two beats.
        send_vec0(8, 1'b1, fill(8, 8'h80), fill(8, 8'h7F), 1'b0);
        wait_idle0();

        // Partial last beat: padded lanes hold 1s and must not count.
        send_vec0(5, 1'b0, fill(8, 1), fill(8, 1), 1'b0);
        wait_idle0();

        // Backpressure: result held for 10 cycles while junk beats are offered.
        man_rdy = 1'b0;
        send_vec0(8, 1'($urandom), fill(8, -1), fill(8, -1), 1'b0);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 10);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1 in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
            @(negedge clk);
            chk("t4_hold_valid", 64'(out_valid), 64'(1));
            chk("t4_hold_in_ready", 64'(in_ready), 64'(0));
            if (sb0.size() != 0) chk("t4_hold_sum", 64'(out_sum), 64'(sb0[0].sum));
        end
        @(posedge clk);
        #1 in_valid = 1'b0; man_rdy = 1'b1;
        @(negedge clk);
        chk("t4_in_ready_at_handshake", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("t4_in_ready_after", 64'(in_ready), 64'(1));
        chk("t4_valid_after", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1 rand_rdy = 1'b1;
        for (int t = 0; t < 3; t++) begin
            int len = $urandom_range(1, 12);
            send_vec0(len, 1'($urandom), fill(len + 4, -1), fill(len + 4, -1), 1'b0);
        end
        wait_idle0();

        // Asynchronous reset mid-vector discards the partial sum.
        rand_rdy = 1'b0; man_rdy = 1'b1;
        drive_beat0(32'h11111111, 32'h11111111, 16'd16, 1'b0);
        drive_beat0(32'h11111111, 32'h11111111, 16'd16, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_in_ready", 64'(in_ready), 64'(1));
        chk("t5_out_valid", 64'(out_valid), 64'(0));
        chk("t5_out_sum", 64'(out_sum), 64'(0));
        chk("t5_out_count", 64'(out_count), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_vec0(4, 1'b0, fill(4, -1), fill(4, -1), 1'b0);
        wait_idle0();

        // Randomized vectors, random gaps and random backpressure.
        rand_rdy = 1'b1;
        for (int t = 0; t < 25; t++) begin
            int len = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 40);
            a = fill(len + 4, -1);
            b = fill(len + 4, -1);
            send_vec0(len, 1'($urandom), a, b, 1'b1);
        end
        wait_idle0();

        waited = 0;
        while (!done1 && waited < 90000) begin
            @(posedge clk);
            #1 waited++;
        end
        chk("dut1_done", 64'(done1), 64'(1));
        chk("sb4_empty", 64'(sb0.size()), 64'(0));
        chk("sb1_empty", 64'(sb1.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
